sram_bus_arbiter: RTL and testbench

- Shares one SRAM-like slave port (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) between two masters: instruction fetch (M0) and the memory stage (M1).
- Sits between the CPU core and the cache/AXI bridge.
- Tracks outstanding transactions in issue order, so each data_ok/rdata response returns to the master that issued it.
- M1 has fixed priority over M0, because a pending load/store stalls the whole pipeline.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/sram_owner_fifo.sv | 66 ++++++
 rtl/sram_bus_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the SRAM-like bus arbiter slice.
//   bus_owner_t : which master owns a request/response (1 bit, stored in the owner FIFO)
//   SIZE_*      : encodings of the 2-bit transfer size field
//   bus_req_t   : request fields that travel with req (wr/size/addr/wdata)
package bus_pkg;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } bus_owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/sram_owner_fifo.sv
// In-order record of which master issued each accepted-but-unanswered request.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears all entries)
//   push, push_id   record a newly accepted request and its owner
//   pop             retire the oldest entry (a slave response arrived)
//   head_id         owner of the oldest outstanding request
//   full, empty     occupancy flags
module sram_owner_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  bus_owner_t push_id,
    input  logic       pop,
    output bus_owner_t head_id,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign head_id = bus_owner_t'(mem[rd_ptr]);

    // A pop on an empty FIFO is a slave error and is ignored. A push that
    // coincides with such a pop is dropped too, so the occupancy stays at
    // zero (the response is treated as having consumed that request).
    // When full, a push is only taken alongside a real pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~(pop & empty) & (~full | do_pop);

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter in front of one SRAM-like slave port.
//   M0 = instruction fetch (inst_*), M1 = memory stage (data_*).
//   M1 wins fixed priority; a request the slave has not yet accepted locks the
//   grant so the slave sees stable fields. Accepted requests are logged in an
//   owner FIFO and each in-order slave response is steered back to its issuer.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wdata      M0 request; inst_addr_ok/data_ok/rdata back
//   data_req/wr/size/addr/wdata      M1 request; data_addr_ok/data_ok/rdata back
//   s_req/wr/size/addr/wdata         request to slave
//   s_addr_ok, s_data_ok, s_rdata    slave handshakes and read data
module sram_bus_arbiter
    import bus_pkg::*;
#(
    parameter int OUTSTANDING = 4   // power of two, >= 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    logic       locked;
    bus_owner_t lock_owner;
    logic       grant_valid;
    bus_owner_t grant;
    logic       sel_data;
    bus_req_t   inst_fields;
    bus_req_t   data_fields;
    bus_req_t   s_fields;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    bus_owner_t head_id;

    // Grant: a pending (unaccepted) request keeps the bus; otherwise M1 first.
    always_comb begin
        grant_valid = 1'b0;
        grant       = OWNER_INST;
        if (locked) begin
            grant_valid = 1'b1;
            grant       = lock_owner;
        end else if (data_req) begin
            grant_valid = 1'b1;
            grant       = OWNER_DATA;
        end else if (inst_req) begin
            grant_valid = 1'b1;
            grant       = OWNER_INST;
        end
    end

    // rst gates the outputs combinationally so an asserted reset silences the
    // slave request and acks immediately, not at the next edge.
    assign s_req    = rst & grant_valid & ~fifo_full;
    assign sel_data = rst & grant_valid & (grant == OWNER_DATA);

    assign inst_fields = '{wr: inst_wr, size: inst_size, addr: inst_addr, wdata: inst_wdata};
    assign data_fields = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};
    assign s_fields    = sel_data ? data_fields : inst_fields;

    assign s_wr    = s_fields.wr;
    assign s_size  = s_fields.size;
    assign s_addr  = s_fields.addr;
    assign s_wdata = s_fields.wdata;

    // Zero-latency forwarding of the slave's address acceptance.
    assign fifo_push    = s_req & s_addr_ok;
    assign inst_addr_ok = fifo_push & (grant == OWNER_INST);
    assign data_addr_ok = fifo_push & (grant == OWNER_DATA);

    // Lock only when a forwarded request stalls; a full-FIFO stall has
    // s_req=0 and therefore never locks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked     <= 1'b0;
            lock_owner <= OWNER_INST;
        end else begin
            locked <= s_req & ~s_addr_ok;
            if (s_req && !s_addr_ok)
                lock_owner <= grant;
        end
    end

    sram_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .push_id (grant),
        .pop     (s_data_ok),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Responses return in order; a response with nothing outstanding is dropped.
    assign inst_data_ok = rst & s_data_ok & ~fifo_empty & (head_id == OWNER_INST);
    assign data_data_ok = rst & s_data_ok & ~fifo_empty & (head_id == OWNER_DATA);
    assign inst_rdata   = s_rdata;
    assign data_rdata   = s_rdata;

`ifndef SYNTHESIS
    a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst)
        (rst && s_data_ok) |-> !fifo_empty)
        else $error("slave data_ok with no outstanding request");

    a_inst_req_held : assert property (@(posedge clk) disable iff (!rst)
        (rst && inst_req && !inst_addr_ok) |=> (!rst || inst_req))
        else $error("inst_req dropped before inst_addr_ok");

    a_data_req_held : assert property (@(posedge clk) disable iff (!rst)
        (rst && data_req && !data_addr_ok) |=> (!rst || data_req))
        else $error("data_req dropped before data_addr_ok");

    a_size_legal : assert property (@(posedge clk) disable iff (!rst)
        (rst && s_req) |-> (s_size <= SIZE_WORD))
        else $error("illegal transfer size");
`endif

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (OUTSTANDING=4). Inputs change 1 time
// unit after the rising edge; combinational outputs are checked 1 unit later.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        inst_req = 1; inst_addr = 32'h1111_0000; inst_wdata = 32'hAAAA_0000;
        data_req = 1; data_addr = 32'h2222_0000; data_wr = 1; data_wdata = 32'hBBBB_0000;
        s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL reset_s_req got %b want 0", s_req); end
        tests++; if (s_addr !== 32'h1111_0000) begin fails++; $display("FAIL reset_s_addr got %h want 11110000", s_addr); end
        tests++; if (s_wr !== 1'b0) begin fails++; $display("FAIL reset_s_wr got %b want 0", s_wr); end
        tests++; if (s_wdata !== 32'hAAAA_0000) begin fails++; $display("FAIL reset_s_wdata got %h want aaaa0000", s_wdata); end
        tests++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            fails++; $display("FAIL reset_acks got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        tests++; if (inst_rdata !== 32'hCAFE_F00D || data_rdata !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL reset_rdata got %h/%h want cafef00d", inst_rdata, data_rdata); end
        idle_inputs();
        #2 rst = 1;
        tick();
    endtask

    task automatic test_single_read();
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; s_addr_ok = 1;
        #1;
        tests++; if (s_req !== 1'b1 || s_addr !== 32'hBFC0_0000) begin fails++; $display("FAIL single_req got %b/%h want 1/bfc00000", s_req, s_addr); end
        tests++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin fails++; $display("FAIL single_addr_ok got %b%b want 10", inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0; s_addr_ok = 0;
        #1;
        tests++; if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0 || s_req !== 1'b0) begin
            fails++; $display("FAIL single_c1 got %b%b%b want 000", inst_data_ok, data_data_ok, s_req); end
        tick();
        s_data_ok = 1; s_rdata = 32'h3C08_0001;
        #1;
        tests++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C08_0001) begin
            fails++; $display("FAIL single_resp got %b/%h want 1/3c080001", inst_data_ok, inst_rdata); end
        tests++; if (data_data_ok !== 1'b0) begin fails++; $display("FAIL single_no_data got %b want 0", data_data_ok); end
        tick();
        s_data_ok = 0;
    endtask

    task automatic test_priority();
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
        s_addr_ok = 1;
        #1;
        tests++; if (s_addr !== 32'h8000_0010 || s_wr !== 1'b1 || s_wdata !== 32'h1234_5678 || s_size !== 2'd2) begin
            fails++; $display("FAIL prio_fields got %h/%b/%h/%0d want 80000010/1/12345678/2", s_addr, s_wr, s_wdata, s_size); end
        tests++; if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin fails++; $display("FAIL prio_first got %b%b want 10", data_addr_ok, inst_addr_ok); end
        tick();
        data_req = 0; data_wr = 0;
        #1;
        tests++; if (s_addr !== 32'hBFC0_0004 || inst_addr_ok !== 1'b1 || s_wr !== 1'b0) begin
            fails++; $display("FAIL prio_second got %h/%b/%b want bfc00004/1/0", s_addr, inst_addr_ok, s_wr); end
        tick();
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000_00A1;
        #1;
        tests++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL prio_resp1 got %b%b want 10", data_data_ok, inst_data_ok); end
        tick();
        s_rdata = 32'h0000_00B2;
        #1;
        tests++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h0000_00B2) begin
            fails++; $display("FAIL prio_resp2 got %b%b/%h want 01/000000b2", inst_data_ok, data_data_ok, inst_rdata); end
        tick();
        s_data_ok = 0;
    endtask

    task automatic test_lock();
        inst_req = 1; inst_addr = 32'h0000_1000; s_addr_ok = 0;
        #1;
        tests++; if (s_req !== 1'b1 || s_addr !== 32'h0000_1000) begin fails++; $display("FAIL lock_c0 got %b/%h want 1/00001000", s_req, s_addr); end
        tick();
        data_req = 1; data_addr = 32'h0000_2000;
        for (int c = 1; c <= 2; c++) begin
            #1;
            tests++; if (s_addr !== 32'h0000_1000 || data_addr_ok !== 1'b0) begin
                fails++; $display("FAIL lock_hold c%0d got %h/%b want 00001000/0", c, s_addr, data_addr_ok); end
            tick();
        end
        s_addr_ok = 1;
        #1;
        tests++; if (s_addr !== 32'h0000_1000 || inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            fails++; $display("FAIL lock_accept got %h/%b%b want 00001000/10", s_addr, inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0;
        #1;
        tests++; if (s_addr !== 32'h0000_2000 || data_addr_ok !== 1'b1) begin fails++; $display("FAIL lock_next got %h/%b want 00002000/1", s_addr, data_addr_ok); end
        tick();
        data_req = 0; s_addr_ok = 0; s_data_ok = 1;
        #1;
        tests++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin fails++; $display("FAIL lock_resp1 got %b%b want 10", inst_data_ok, data_data_ok); end
        tick();
        #1;
        tests++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL lock_resp2 got %b%b want 10", data_data_ok, inst_data_ok); end
        tick();
        s_data_ok = 0;
    endtask

    task automatic test_full();
        inst_req = 1; s_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'h0000_0100 + 32'(i * 4);
            #1;
            tests++; if (inst_addr_ok !== 1'b1) begin fails++; $display("FAIL full_fill%0d got %b want 1", i, inst_addr_ok); end
            tick();
        end
        inst_addr = 32'h0000_0200;
        #1;
        tests++; if (s_req !== 1'b0 || inst_addr_ok !== 1'b0) begin fails++; $display("FAIL full_block got %b%b want 00", s_req, inst_addr_ok); end
        tick();
        s_data_ok = 1;
        #1;
        tests++; if (s_req !== 1'b0 || inst_data_ok !== 1'b1) begin fails++; $display("FAIL full_pop_cycle got %b%b want 01", s_req, inst_data_ok); end
        tick();
        #1;
        tests++; if (s_req !== 1'b1 || inst_addr_ok !== 1'b1 || inst_data_ok !== 1'b1) begin
            fails++; $display("FAIL full_push_pop got %b%b%b want 111", s_req, inst_addr_ok, inst_data_ok); end
        tick();
        s_data_ok = 0; inst_addr = 32'h0000_0204;
        #1;
        tests++; if (s_req !== 1'b1 || inst_addr_ok !== 1'b1) begin fails++; $display("FAIL full_refill got %b%b want 11", s_req, inst_addr_ok); end
        tick();
        inst_addr = 32'h0000_0208;
        #1;
        tests++; if (s_req !== 1'b0) begin fails++; $display("FAIL full_again got %b want 0", s_req); end
        tick();
        s_data_ok = 1; s_addr_ok = 0;
        #1;
        tests++; if (s_req !== 1'b0 || inst_data_ok !== 1'b1) begin fails++; $display("FAIL full_pop2 got %b%b want 01", s_req, inst_data_ok); end
        tick();
        s_data_ok = 0; s_addr_ok = 1;
        #1;
        tests++; if (inst_addr_ok !== 1'b1) begin fails++; $display("FAIL full_reassert got %b want 1", inst_addr_ok); end
        tick();
        inst_req = 0; s_addr_ok = 0; s_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
                fails++; $display("FAIL full_drain%0d got %b%b want 10", i, inst_data_ok, data_data_ok); end
            tick();
        end
        s_data_ok = 0;
    endtask

    task automatic test_interleave();
        logic [3:0] is_data;
        is_data = 4'b0110;  // issue order M0,M1,M1,M0 (bit i = slot i)
        for (int r = 0; r < 3; r++) begin
            s_addr_ok = 1;
            for (int i = 0; i < 4; i++) begin
                inst_req = ~is_data[i]; data_req = is_data[i];
                inst_addr = 32'h0000_3000 + 32'(i); data_addr = 32'h0000_4000 + 32'(i);
                #1;
                tests++; if ({data_addr_ok, inst_addr_ok} !== {is_data[i], ~is_data[i]}) begin
                    fails++; $display("FAIL ilv_push r%0d i%0d got %b%b want %b%b", r, i, data_addr_ok, inst_addr_ok, is_data[i], ~is_data[i]); end
                tick();
            end
            inst_req = 0; data_req = 0; s_addr_ok = 0; s_data_ok = 1;
            for (int i = 0; i < 4; i++) begin
                s_rdata = 32'(i + 1);
                #1;
                tests++; if ({data_data_ok, inst_data_ok} !== {is_data[i], ~is_data[i]} || data_rdata !== 32'(i + 1)) begin
                    fails++; $display("FAIL ilv_resp r%0d i%0d got %b%b/%h want %b%b/%h", r, i, data_data_ok, inst_data_ok, data_rdata, is_data[i], ~is_data[i], i + 1); end
                tick();
            end
            s_data_ok = 0;
        end
    endtask

    task automatic test_reset_mid();
        inst_req = 1; inst_addr = 32'h0000_5000; s_addr_ok = 1;
        #1;
        tests++; if (inst_addr_ok !== 1'b1) begin fails++; $display("FAIL rmid_push0 got %b want 1", inst_addr_ok); end
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h0000_5004;
        #1;
        tests++; if (data_addr_ok !== 1'b1) begin fails++; $display("FAIL rmid_push1 got %b want 1", data_addr_ok); end
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h0000_5008;
        #1;
        tests++; if (s_req !== 1'b1 || inst_addr_ok !== 1'b1) begin fails++; $display("FAIL rmid_pre got %b%b want 11", s_req, inst_addr_ok); end
        #1 rst = 0;
        #1;
        tests++; if (s_req !== 1'b0 || inst_addr_ok !== 1'b0 || data_addr_ok !== 1'b0) begin
            fails++; $display("FAIL rmid_async got %b%b%b want 000", s_req, inst_addr_ok, data_addr_ok); end
        tick();
        inst_req = 0; s_addr_ok = 0;
        #2 rst = 1;
        tick();
        data_req = 1; data_addr = 32'h0000_6000; s_addr_ok = 1;
        #1;
        tests++; if (data_addr_ok !== 1'b1 || s_addr !== 32'h0000_6000) begin fails++; $display("FAIL rmid_regrant got %b/%h want 1/00006000", data_addr_ok, s_addr); end
        tick();
        data_req = 0; s_addr_ok = 0; s_data_ok = 1; s_rdata = 32'h0000_0077;
        #1;
        tests++; if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin fails++; $display("FAIL rmid_fifo_clear got %b%b want 10", data_data_ok, inst_data_ok); end
        tick();
        s_data_ok = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_priority();
        test_lock();
        test_full();
        test_interleave();
        test_reset_mid();
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
